golomb_bit_packer: RTL and testbench
====================================

Name: golomb_bit_packer

Overview:
Downstream stage of the exp-Golomb/Rice codeword generator in the ProRes entropy path. Takes (codeword value, codeword length) pairs and packs them MSB-first into a contiguous bitstream. Emits 32-bit big-endian words with a valid/ready handshake toward the slice output buffer. On request, flushes a partial word zero-padded to the 32-bit boundary.

Parameters:
MAX_LEN, 32, largest legal codeword length in bits; larger lengths are clamped.
CNT_W, 32, width of the emitted-word counter.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  codeword present
in_ready  output  1  packer can accept a codeword this cycle
in_code  input  32  codeword value; only the low in_len bits are used
in_len  input  32  codeword length in bits (codeword_length from the Golomb stage)
flush  input  1  single-cycle pulse: pad and emit the pending partial word
flush_done  output  1  single-cycle pulse when the flush has completed
out_valid  output  1  out_word holds a packed word
out_ready  input  1  consumer takes out_word
out_word  output  32  packed bits; the first bit in is at bit 31
word_count  output  CNT_W  number of words transferred on the output handshake
len_err  output  1  sticky flag: an in_len greater than MAX_LEN was seen

Behaviour:
- Reset is asynchronous and active-low on reset_n. All state clears: acc=0, fill=0, state=RUN, out_valid=0, out_word=0, flush_done=0, word_count=0, len_err=0. Reset mid-operation discards pending bits and does not emit them.
- State:
  - acc[63:0] is a left-aligned bit accumulator.
  - fill is a 7-bit count of valid bits, range 0..64.
  - A 32-bit output holding register drives out_word/out_valid.
- Effective length: L = min(in_len, MAX_LEN). If in_len > MAX_LEN on an accepted beat, len_err is set to 1 and stays set until reset.
- Mask: code_m = in_code & ((1<<L)-1). For L=32 the mask is all ones, with no shift overflow.
- in_ready = (state==RUN) && (fill <= 32). It is combinational from registers only.
- Output slot free: slot_free = !out_valid || out_ready.
- Drain: if slot_free && fill >= 32, then out_word <= acc[63:32], out_valid <= 1, and the accumulator is shifted left by 32 with fill reduced by 32. Otherwise, if out_ready, out_valid <= 0.
- Accept: on in_valid && in_ready, code_m is ORed at bit position (63 - fill' - L + 1), where fill' is fill after any same-cycle drain. Then fill <= fill' + L.
- Drain and accept in the same cycle are both applied. Accept always uses post-drain alignment.
- L=0 is accepted and changes nothing.
- word_count increments on every out_valid && out_ready. It wraps modulo 2^CNT_W.
- Latency: the first word appears on out_valid 1 cycle after the beat that makes fill >= 32, given slot_free.
- Throughput: one codeword per cycle with up to 32 bits each, sustained while out_ready=1.
- FSM:
  - RUN: a flush pulse moves to FLUSH. A flush in the same cycle as an accepted beat includes that beat.
  - FLUSH: in_ready=0. Normal drains continue. When fill < 32:
    - if fill > 0, set fill=32; the pad bits are already zero in acc. Go to FLUSH_WAIT.
    - if fill == 0, go to FLUSH_WAIT directly.
  - FLUSH_WAIT: wait until fill==0 and (out_valid==0 or out_ready). Then pulse flush_done for 1 cycle and return to RUN.
  - A flush pulse received while in FLUSH or FLUSH_WAIT is ignored.
  - A flush with nothing pending produces no word, and flush_done follows within 2 cycles.
- Backpressure: with out_ready=0 and the slot full, fill can reach 64. in_ready stays 0 while fill > 32. No bits are lost or duplicated.

Decomposition:
- Shared package, prores_pkg:
  - constant WORD_W=32
  - constant ACC_W=64
  - packer state enum {RUN, FLUSH, FLUSH_WAIT}
  - function len_mask(L)
- One natural sub-module, bit_align_insert: combinational placement of code_m into a 64-bit accumulator given fill' and L. It is kept separate so it can be unit-tested.

Test Plan:
- Eight beats of code=0xF, len=4, out_ready=1 -> a single word 0xFFFFFFFF; word_count=1; fill=0.
- code=0x5, len=3, then flush -> word 0xA0000000, then a flush_done pulse; word_count=1.
- code=0xABCDE len=20, then code=0x12345 len=20, then flush -> words 0xABCDE123 then 0x45000000.
- Back-to-back code=0x12345678 len=32 ×3 with out_ready=1 -> in_ready stays 1 and three words of 0x12345678 come out on consecutive cycles.
- out_ready=0, feed len=32 beats -> in_ready drops after fill exceeds 32. Releasing out_ready drains the words in order with no loss.
- Edge cases:
  - code=0xFFFFFFFF len=4 then flush -> 0xF0000000 (upper bits are masked).
  - len=40 -> len_err=1 (sticky), and the beat is treated as 32 bits.
  - Reset asserted mid-stream -> all outputs return to zero immediately.

Source files
------------

// File: rtl/prores_pkg.sv
// Shared types and constants for the ProRes entropy-path bit packer.
package prores_pkg;

    localparam int WORD_W = 32;
    localparam int ACC_W  = 64;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        FLUSH_WAIT = 2'd2
    } pack_state_t;

    // Mask of the low len bits; computed one bit wider so len=32 needs no overflowing shift.
    function automatic logic [WORD_W-1:0] len_mask(input logic [5:0] len);
        logic [WORD_W:0] wide;
        wide = ((WORD_W+1)'(1) << len) - (WORD_W+1)'(1);
        return wide[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/golomb_bit_packer_if.sv
// Codeword input stream and packed-word output stream of the bit packer.
interface golomb_bit_packer_if;
    import prores_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_code;
    logic [31:0]       in_len;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;

    modport master (
        output in_valid, in_code, in_len, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_code, in_len, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/golomb_bit_packer_bit_align_insert.sv
// Purpose: OR a masked codeword into a left-aligned 64-bit accumulator below fill bits.
// Latency: combinational.
// Backpressure: none; caller guarantees fill + len <= 64.
module bit_align_insert
    import prores_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [6:0]        fill,
    input  logic [5:0]        len,
    input  logic [WORD_W-1:0] code,
    output logic [ACC_W-1:0]  acc_out
);
    logic [6:0] shamt;

    // The codeword's LSB lands at bit 64 - fill - len; a shift of 64 only happens with len=0.
    always_comb begin
        shamt   = 7'd64 - fill - {1'b0, len};
        acc_out = acc_in | ({{(ACC_W-WORD_W){1'b0}}, code} << shamt);
    end
endmodule

// File: rtl/golomb_bit_packer.sv
// Purpose: pack (code, len) beats MSB-first into 32-bit big-endian words, with flush-to-boundary.
// Latency: a word is presented 1 cycle after the beat that completes it, if the output slot is free.
// Backpressure: up to 64 bits buffered; in_ready drops while more than 32 bits are pending.
module golomb_bit_packer
    import prores_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    golomb_bit_packer_if.slave  bus,
    input  logic                flush,
    output logic                flush_done,
    output logic [CNT_W-1:0]    word_count,
    output logic                len_err
);
    localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);
    localparam logic [5:0]  MAX_L     = 6'(MAX_LEN);

    pack_state_t       state;
    logic [ACC_W-1:0]  acc;
    logic [6:0]        fill;
    logic [WORD_W-1:0] out_word_q;
    logic              out_valid_q;

    logic              in_ready_c;
    logic              slot_free;
    logic              drain;
    logic              accept;
    logic              len_over;
    logic [5:0]        eff_len;
    logic [WORD_W-1:0] code_m;
    logic [ACC_W-1:0]  acc_d;
    logic [6:0]        fill_d;
    logic [ACC_W-1:0]  acc_ins;
    logic [ACC_W-1:0]  acc_next;
    logic [6:0]        fill_next;

    always_comb begin
        in_ready_c = (state == RUN) && (fill <= 7'd32);
        slot_free  = !out_valid_q || bus.out_ready;
        drain      = slot_free && (fill >= 7'd32);
        accept     = bus.in_valid && in_ready_c;
        len_over   = bus.in_len > MAX_LEN_U;
        eff_len    = len_over ? MAX_L : bus.in_len[5:0];
        code_m     = bus.in_code & len_mask(eff_len);
        acc_d      = drain ? {acc[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}} : acc;
        fill_d     = drain ? fill - 7'd32 : fill;
        acc_next   = accept ? acc_ins : acc_d;
        fill_next  = accept ? fill_d + {1'b0, eff_len} : fill_d;
    end

    // Insertion always sees the post-drain accumulator so a same-cycle drain and accept compose.
    bit_align_insert u_align (
        .acc_in  (acc_d),
        .fill    (fill_d),
        .len     (eff_len),
        .code    (code_m),
        .acc_out (acc_ins)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            acc         <= '0;
            fill        <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            flush_done  <= 1'b0;
            word_count  <= '0;
            len_err     <= 1'b0;
        end else begin
            acc        <= acc_next;
            fill       <= fill_next;
            flush_done <= 1'b0;

            if (drain) begin
                out_word_q  <= acc[ACC_W-1:ACC_W-WORD_W];
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && bus.out_ready)
                word_count <= word_count + CNT_W'(1);

            if (accept && len_over)
                len_err <= 1'b1;

            case (state)
                RUN: begin
                    if (flush)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Bits below fill are already zero, so padding is just rounding fill up.
                    if (fill < 7'd32) begin
                        if (fill != 7'd0)
                            fill <= 7'd32;
                        state <= FLUSH_WAIT;
                    end
                end
                FLUSH_WAIT: begin
                    if (fill == 7'd0 && slot_free) begin
                        flush_done <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
endmodule

// File: tb/tb_golomb_bit_packer.sv
// Bench for golomb_bit_packer: bit-queue reference model plus directed literal vectors.
module tb_golomb_bit_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        len_err;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;

    golomb_bit_packer_if bus();

    golomb_bit_packer #(.MAX_LEN(32), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .word_count (word_count),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    // Reference model: the stream as a plain queue of bits, cut into words 32 at a time.
    bit          bq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          m_count = 0;
    bit          m_len_err = 1'b0;
    bit          flushing = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        int          len_eff;
        logic [31:0] w;
        if (!reset_n) begin
            bq.delete();
            exp_q.delete();
            got.delete();
            got_cyc.delete();
            m_count   = 0;
            m_len_err = 1'b0;
            flushing  = 1'b0;
        end else begin
            cyc++;
            chk("word_count", word_count, m_count);
            chk("len_err", len_err, m_len_err);
            if (flush_done) begin
                chk("flush_done_when_flushing", flushing, 1);
                chk("flush_done_drained", exp_q.size() + bq.size(), 0);
                flushing = 1'b0;
            end
            if (flushing)
                chk("in_ready_in_flush", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("out_word", bus.out_word, exp_q.pop_front());
                got.push_back(bus.out_word);
                got_cyc.push_back(cyc);
                m_count++;
            end
            if (bus.in_valid && bus.in_ready) begin
                len_eff = (bus.in_len > 32) ? 32 : int'(bus.in_len);
                if (bus.in_len > 32)
                    m_len_err = 1'b1;
                for (int i = len_eff - 1; i >= 0; i--)
                    bq.push_back(bus.in_code[i]);
            end
            if (flush && !flushing) begin
                flushing = 1'b1;
                while (bq.size() % 32 != 0)
                    bq.push_back(1'b0);
            end
            while (bq.size() >= 32) begin
                for (int i = 31; i >= 0; i--)
                    w[i] = bq.pop_front();
                exp_q.push_back(w);
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] code, input logic [31:0] len, output int waited);
        bit took;
        took   = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        bus.in_len   = len;
        while (!took && waited < 50) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", took, 1);
    endtask

    task automatic snd(input logic [31:0] code, input logic [31:0] len);
        int dummy;
        send(code, len, dummy);
    endtask

    task automatic do_flush(input string nm, input int budget);
        bit seen;
        seen  = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (flush_done)
                seen = 1'b1;
        end
        chk(nm, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_word", bus.out_word, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_flush_done", flush_done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        settle(1);
    endtask

    task automatic chk_words(input string nm, input int n, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev[4];
        ev[0] = e0;
        ev[1] = e1;
        ev[2] = e2;
        ev[3] = e3;
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk(nm, got[i], ev[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t4_wait;
        int w;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_len    = '0;
        bus.out_ready = 1'b1;
        do_reset();

        // Eight nibbles of ones fill exactly one word; a following flush has nothing to emit.
        for (int i = 0; i < 8; i++)
            snd(32'hF, 32'd4);
        settle(4);
        chk_words("t1_word", 1, 32'hFFFFFFFF, 0, 0, 0);
        chk("t1_word_count", word_count, 1);
        do_flush("t1_empty_flush_done", 3);
        settle(2);
        chk_words("t1_no_extra", 1, 32'hFFFFFFFF, 0, 0, 0);

        do_reset();
        snd(32'h5, 32'd3);
        do_flush("t2_flush_done", 8);
        settle(1);
        chk_words("t2_word", 1, 32'hA0000000, 0, 0, 0);
        chk("t2_word_count", word_count, 1);

        // A zero-length beat between the two codewords contributes nothing.
        do_reset();
        snd(32'hABCDE, 32'd20);
        snd(32'hFFFFFFFF, 32'd0);
        snd(32'h12345, 32'd20);
        do_flush("t3_flush_done", 10);
        chk_words("t3_words", 2, 32'hABCDE123, 32'h45000000, 0, 0);

        do_reset();
        t4_wait = 0;
        for (int i = 0; i < 3; i++) begin
            send(32'h12345678, 32'd32, w);
            t4_wait += w;
        end
        settle(5);
        chk("t4_accept_cycles", t4_wait, 3);
        chk_words("t4_words", 3, 32'h12345678, 32'h12345678, 32'h12345678, 0);
        if (got_cyc.size() == 3)
            chk("t4_consecutive", got_cyc[2] - got_cyc[0], 2);

        do_reset();
        bus.out_ready = 1'b0;
        snd(32'h11111111, 32'd32);
        snd(32'h22222222, 32'd32);
        snd(32'h33333333, 32'd32);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_in_ready_low", bus.in_ready, 0);
            chk("t5_hold_word", bus.out_word, 32'h11111111);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        snd(32'h44444444, 32'd32);
        settle(6);
        chk_words("t5_words", 4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

        do_reset();
        snd(32'hFFFFFFFF, 32'd4);
        do_flush("t6_flush_done", 8);
        chk_words("t6_word", 1, 32'hF0000000, 0, 0, 0);

        do_reset();
        snd(32'hCAFEF00D, 32'd40);
        settle(3);
        chk("t7_len_err_set", len_err, 1);
        snd(32'h1, 32'd1);
        do_flush("t7_flush_done", 8);
        chk("t7_len_err_sticky", len_err, 1);
        chk_words("t7_words", 2, 32'hCAFEF00D, 32'h80000000, 0, 0);

        // Reset while a word is presented and more bits are pending; none of it survives.
        do_reset();
        bus.out_ready = 1'b0;
        snd(32'hAAAAAAAA, 32'd32);
        snd(32'hBBBBBBBB, 32'd32);
        @(negedge clk);
        chk("t8_pre_valid", bus.out_valid, 1);
        do_reset();
        snd(32'h3, 32'd2);
        do_flush("t8_flush_done", 8);
        chk_words("t8_after_reset", 1, 32'hC0000000, 0, 0, 0);

        settle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
